// File: rtl/p_mul_unit.sv
// ============================================================================
// Module      : p_mul_unit
// Description : Multi-cycle packed (SIMD) shift-add multiplier, 32-bit operands
//               split into 1x32/2x16/4x8/8x4/16x2-bit unsigned lanes.
//               Optional carry-less lane multiply enabled by macro P_MUL_CLMUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p_mul_unit (
    input  logic        clock,
    input  logic        resetn,
    input  logic        valid,
    output logic        ready,
    input  logic        mul_l,
    input  logic        mul_h,
    input  logic        clmul,
    input  logic [4:0]  pw,
    input  logic [31:0] crs1,
    input  logic [31:0] crs2,
    output logic [31:0] result
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUSY = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [4:0]       r_cnt;
    logic [63:0]      r_prod;

    logic [2:0]       w_sel;
    logic             w_pw_ok;
    logic [4:0]       w_wmask;
    logic [31:0]      w_lmask;
    logic [4:0]       w_base;
    logic [31:0]      w_lane;
    logic [5:0]       w_shamt;
    logic [63:0]      w_pp;
    logic [63:0]      w_sum;
    logic [4:0][63:0] w_perm;
    logic [63:0]      w_acc;

    // Lane width decode: the highest set pw bit (narrowest lane) wins.
    always_comb begin
        w_sel   = 3'd0;
        w_pw_ok = 1'b1;
        w_wmask = 5'd0;
        w_lmask = 32'd0;
        if (pw[4]) begin
            w_sel = 3'd4; w_wmask = 5'd1;  w_lmask = 32'h0000_0003;
        end else if (pw[3]) begin
            w_sel = 3'd3; w_wmask = 5'd3;  w_lmask = 32'h0000_000F;
        end else if (pw[2]) begin
            w_sel = 3'd2; w_wmask = 5'd7;  w_lmask = 32'h0000_00FF;
        end else if (pw[1]) begin
            w_sel = 3'd1; w_wmask = 5'd15; w_lmask = 32'h0000_FFFF;
        end else if (pw[0]) begin
            w_sel = 3'd0; w_wmask = 5'd31; w_lmask = 32'hFFFF_FFFF;
        end else begin
            w_pw_ok = 1'b0;
        end
    end

    // r_prod keeps lane k's 2w-bit product at bit 2w*k. Multiplier bit r_cnt
    // sits at offset j of the lane starting at w_base, so its partial product
    // lands at 2*w_base + j = w_base + r_cnt.
    assign w_base  = r_cnt & ~w_wmask;
    assign w_lane  = (crs1 >> w_base) & w_lmask;
    assign w_shamt = {1'b0, r_cnt} + {1'b0, w_base};
    assign w_pp    = (crs2[r_cnt] && w_pw_ok) ? ({32'd0, w_lane} << w_shamt) : 64'd0;

`ifdef P_MUL_CLMUL_EN
    assign w_sum = clmul ? (r_prod ^ w_pp) : (r_prod + w_pp);
`else
    logic w_unused_clmul;
    assign w_unused_clmul = clmul;
    // A partial lane sum never exceeds 2w bits, so the wide add cannot carry across lanes.
    assign w_sum = r_prod + w_pp;
`endif

    // Rearrange lane products into {high halves, low halves} for each width.
    for (genvar g = 0; g < 5; g++) begin : g_width
        localparam int c_W = 32 >> g;
        for (genvar k = 0; k < 32 / c_W; k++) begin : g_lane
            assign w_perm[g][c_W*k +: c_W]      = r_prod[2*c_W*k +: c_W];
            assign w_perm[g][32 + c_W*k +: c_W] = r_prod[2*c_W*k + c_W +: c_W];
        end
    end

    always_comb begin
        w_acc = 64'd0;
        if (w_pw_ok) begin
            case (w_sel)
                3'd0:    w_acc = w_perm[0];
                3'd1:    w_acc = w_perm[1];
                3'd2:    w_acc = w_perm[2];
                3'd3:    w_acc = w_perm[3];
                default: w_acc = w_perm[4];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (valid) w_next_state = c_ST_BUSY;
            c_ST_BUSY: begin
                if (!valid) begin
                    w_next_state = c_ST_IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next_state = c_ST_DONE;
                end
            end
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (resetn) begin
            r_cnt  <= 5'd0;
            r_prod <= 64'd0;
        end else if ((r_state == c_ST_IDLE) && valid) begin
            r_cnt  <= 5'd0;
            r_prod <= 64'd0;
        end else if ((r_state == c_ST_BUSY) && valid) begin
            r_cnt  <= r_cnt + 5'd1;
            r_prod <= w_sum;
        end
    end

    // Gating with valid keeps ready low whenever the request is withdrawn.
    always_comb begin
        ready  = (r_state == c_ST_DONE) && valid;
        result = 32'd0;
        if (ready) begin
            if (mul_l) begin
                result = w_acc[31:0];
            end else if (mul_h) begin
                result = w_acc[63:32];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_p_mul_unit.sv
// ============================================================================
// Module      : tb_p_mul_unit
// Description : Self-checking bench for p_mul_unit; directed and random
//               operations compared against a lane-level arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_p_mul_unit;

    logic        clock = 1'b0;
    logic        resetn;
    logic        valid;
    logic        ready;
    logic        mul_l;
    logic        mul_h;
    logic        clmul;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    p_mul_unit dut (
        .clock  (clock),
        .resetn (resetn),
        .valid  (valid),
        .ready  (ready),
        .mul_l  (mul_l),
        .mul_h  (mul_h),
        .clmul  (clmul),
        .pw     (pw),
        .crs1   (crs1),
        .crs2   (crs2),
        .result (result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each lane multiplied directly, then halves packed into result words.
    function automatic logic [31:0] model(input logic [4:0] p, input logic [31:0] a,
                                          input logic [31:0] b, input logic ml,
                                          input logic mh, input logic clm);
        int          w;
        logic [63:0] lo, hi, m, av, bv, prod;
        w  = p[4] ? 2 : p[3] ? 4 : p[2] ? 8 : p[1] ? 16 : p[0] ? 32 : 0;
        lo = 64'd0;
        hi = 64'd0;
        if (w != 0) begin
            m = (64'd1 << w) - 64'd1;
            for (int k = 0; k < 32 / w; k++) begin
                av   = (64'(a) >> (k * w)) & m;
                bv   = (64'(b) >> (k * w)) & m;
                prod = av * bv;
`ifdef P_MUL_CLMUL_EN
                if (clm) begin
                    prod = 64'd0;
                    for (int j = 0; j < w; j++) if (bv[j]) prod = prod ^ (av << j);
                end
`endif
                lo = lo | ((prod & m) << (k * w));
                hi = hi | (((prod >> w) & m) << (k * w));
            end
        end
        return ml ? lo[31:0] : (mh ? hi[31:0] : 32'd0);
    endfunction

    task automatic run_op(input string tag, input logic [4:0] p, input logic [31:0] a,
                          input logic [31:0] b, input logic ml, input logic mh,
                          input logic clm, input logic [31:0] exp);
        int lat;
        pw = p; crs1 = a; crs2 = b; mul_l = ml; mul_h = mh; clmul = clm;
        valid = 1'b1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (ready) begin
                lat = c;
                break;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " result"}, {32'd0, result}, {32'd0, exp});
        valid = 1'b0;
        #1;
        check({tag, " ready_low"}, {63'd0, ready}, 64'd0);
        @(negedge clock);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          pulses;
        int          lat;
        logic [4:0]  rp;
        logic [31:0] ra, rb;
        logic        rl, rh, rc;

        resetn = 1'b1; valid = 1'b0; mul_l = 1'b0; mul_h = 1'b0; clmul = 1'b0;
        pw = 5'd0; crs1 = 32'd0; crs2 = 32'd0;
        repeat (3) @(negedge clock);
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        resetn = 1'b0;
        @(negedge clock);

        run_op("t1_l", 5'b00001, 32'h10, 32'h10, 1, 0, 0, 32'h0000_0100);
        run_op("t1_h", 5'b00001, 32'h10, 32'h10, 0, 1, 0, 32'h0000_0000);
        run_op("t2_h", 5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'hFFFF_FFFE);
        run_op("t2_l", 5'b00001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'h0000_0001);
        run_op("t3_l", 5'b00010, 32'h0003_FFFF, 32'h0002_FFFF, 1, 0, 0, 32'h0006_0001);
        run_op("t3_h", 5'b00010, 32'h0003_FFFF, 32'h0002_FFFF, 0, 1, 0, 32'h0000_FFFE);
        run_op("t4_l", 5'b00100, 32'h1010_1010, 32'h1010_1010, 1, 0, 0, 32'h0000_0000);
        run_op("t4_h", 5'b00100, 32'h1010_1010, 32'h1010_1010, 0, 1, 0, 32'h0101_0101);
        run_op("t5_l", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'h5555_5555);
        run_op("t5_h", 5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'hAAAA_AAAA);
        run_op("w4_h", 5'b01000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 32'hEEEE_EEEE);
        run_op("l_prio", 5'b00001, 32'h10, 32'h10, 1, 1, 0, 32'h0000_0100);
        run_op("no_half", 5'b00001, 32'h10, 32'h10, 0, 0, 0, 32'h0000_0000);
        run_op("pw_zero", 5'b00000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'h0000_0000);
        run_op("pw_multi", 5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32'h5555_5555);
`ifdef P_MUL_CLMUL_EN
        run_op("clmul", 5'b00001, 32'd3, 32'd3, 1, 0, 1, 32'h0000_0005);
`else
        run_op("clmul_ign", 5'b00001, 32'd3, 32'd3, 1, 0, 1, 32'h0000_0009);
`endif

        for (int i = 0; i < 24; i++) begin
            rp = (i % 2 == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            rl = 1'($urandom_range(0, 1));
            rh = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d", i), rp, ra, rb, rl, rh, rc, model(rp, ra, rb, rl, rh, rc));
        end

        // Withdraw the request after 10 cycles: no ready may follow.
        pw = 5'b00001; crs1 = 32'h1234_5678; crs2 = 32'h9ABC_DEF0; mul_l = 1'b1;
        mul_h = 1'b0; clmul = 1'b0; valid = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        valid = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (ready) pulses++;
        end
        check("abort no_ready", 64'(pulses), 64'd0);
        run_op("post_abort", 5'b00010, 32'h0003_FFFF, 32'h0002_FFFF, 1, 0, 0, 32'h0006_0001);

        // Reset in the middle of an operation, then restart with valid still high.
        pw = 5'b00100; crs1 = 32'h1010_1010; crs2 = 32'h1010_1010; mul_l = 1'b0;
        mul_h = 1'b1; clmul = 1'b0; valid = 1'b1;
        repeat (15) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("midreset ready", {63'd0, ready}, 64'd0);
        check("midreset result", {32'd0, result}, 64'd0);
        resetn = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (ready) begin
                lat = c;
                break;
            end
        end
        check("midreset latency", 64'(lat), 64'd33);
        check("midreset result2", {32'd0, result}, 64'h0101_0101);
        valid = 1'b0;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
